// File: rtl/ws_array_feeder.sv
// Upstream feeder for an N x N weight-stationary MAC array: loads weight rows,
// skews activation vectors onto the array's left edge, then drains the skew.
module ws_array_feeder #(
    parameter int N         = 4,
    parameter int bit_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wt_valid,
    output logic                   wt_ready,
    input  logic [N*bit_width-1:0] wt_row_in,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [N*bit_width-1:0] act_vec_in,
    input  logic                   act_last,
    output logic                   control,
    output logic [N*bit_width-1:0] wt_out,
    output logic [N*bit_width-1:0] data_out,
    output logic [N-1:0]           data_vld,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = N * bit_width;
    localparam int CW = $clog2(N + 1);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((N > 1) ? (N - 2) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   load_cnt_r;
    logic [CW-1:0]   load_cnt_s;
    logic [DW-1:0]   drain_cnt_r;
    logic [DW-1:0]   drain_cnt_s;
    logic            done_s;
    logic            done_r;
    logic            control_r;
    logic [W-1:0]    wt_out_r;
    logic            wt_accept_s;
    logic            act_accept_s;

    assign wt_ready     = (state_r == IDLE) || (state_r == LOAD);
    assign act_ready    = (state_r == STREAM);
    assign wt_accept_s  = wt_valid && wt_ready;
    assign act_accept_s = act_valid && act_ready;
    assign busy         = (state_r != IDLE);
    assign done         = done_r;
    assign control      = control_r;
    assign wt_out       = wt_out_r;

    // Next-state and counter logic for the load/stream/drain sequence.
    always_comb begin
        state_s     = state_r;
        load_cnt_s  = load_cnt_r;
        drain_cnt_s = drain_cnt_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (wt_accept_s) begin
                    if (N == 1) begin
                        state_s = STREAM;
                    end else begin
                        state_s    = LOAD;
                        load_cnt_s = CW'(1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (wt_accept_s) begin
                    load_cnt_s = load_cnt_r + CW'(1);
                    if (load_cnt_r == LOAD_LAST) begin
                        state_s = STREAM;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            STREAM: begin
                load_cnt_s = '0;
                if (act_accept_s && act_last) begin
                    if (N == 1) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s     = DRAIN;
                        drain_cnt_s = '0;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_s     = IDLE;
                    done_s      = 1'b1;
                    drain_cnt_s = '0;
                end else begin
                    drain_cnt_s = drain_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and the done pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            load_cnt_r  <= '0;
            drain_cnt_r <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            load_cnt_r  <= load_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            done_r      <= done_s;
        end
    end

    // Weight path: an accepted row is presented with control=1 on the next cycle; otherwise the row holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control_r <= 1'b0;
            wt_out_r  <= '0;
        end else begin
            control_r <= wt_accept_s;
            wt_out_r  <= wt_accept_s ? wt_row_in : wt_out_r;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [k:0][bit_width-1:0] dpipe_r;
        logic [k:0]                vpipe_r;

        // Lane k: k skew stages plus the output register; bubbles enter as zero/invalid.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dpipe_r <= '0;
                vpipe_r <= '0;
            end else begin
                dpipe_r[0] <= act_accept_s ? act_vec_in[k*bit_width +: bit_width] : {bit_width{1'b0}};
                vpipe_r[0] <= act_accept_s;
                for (int j = 1; j <= k; j++) begin
                    dpipe_r[j] <= dpipe_r[j-1];
                    vpipe_r[j] <= vpipe_r[j-1];
                end
            end
        end

        assign data_out[k*bit_width +: bit_width] = dpipe_r[k];
        assign data_vld[k]                        = vpipe_r[k];
    end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Directed bench for ws_array_feeder (N=4, bit_width=8): weight load, stall,
// activation skew, bubbles, drain/done and asynchronous reset.
module tb_ws_array_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wt_valid;
    logic        wt_ready;
    logic [31:0] wt_row_in;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_vec_in;
    logic        act_last;
    logic        control;
    logic [31:0] wt_out;
    logic [31:0] data_out;
    logic [3:0]  data_vld;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    ws_array_feeder #(.N(4), .bit_width(8)) dut (
        .clk(clk), .reset(reset),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row_in(wt_row_in),
        .act_valid(act_valid), .act_ready(act_ready), .act_vec_in(act_vec_in), .act_last(act_last),
        .control(control), .wt_out(wt_out), .data_out(data_out), .data_vld(data_vld),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wt_valid = 1'b0; wt_row_in = 32'h0; act_valid = 1'b0;
        act_vec_in = 32'h0; act_last = 1'b0;
        #12;
        checks++; if ({control, busy, done, act_ready} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {control, busy, done, act_ready}); end
        checks++; if (wt_ready !== 1'b1) begin errors++; $display("FAIL reset_wt_ready: got %b expected 1", wt_ready); end
        checks++; if ({data_out, data_vld, wt_out} !== 68'h0) begin errors++; $display("FAIL reset_data: got %h/%b/%h expected 0", data_out, data_vld, wt_out); end
        @(negedge clk); reset = 1'b1;
        step();
    endtask

    task automatic test_load_b2b();
        logic [31:0] rows [4];
        rows[0] = 32'h04040404; rows[1] = 32'h03030303; rows[2] = 32'h02020202; rows[3] = 32'h01010101;
        for (int i = 0; i < 4; i++) begin
            wt_valid = 1'b1; wt_row_in = rows[i];
            step();
            checks++; if (control !== 1'b1 || wt_out !== rows[i]) begin errors++; $display("FAIL load_row%0d: got ctl=%b wt=%h expected ctl=1 wt=%h", i, control, wt_out, rows[i]); end
        end
        checks++; if (wt_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL load_end: got wt_ready=%b busy=%b expected 0/1", wt_ready, busy); end
        wt_valid = 1'b0;
        step();
        checks++; if (control !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL load_after: got ctl=%b act_ready=%b expected 0/1", control, act_ready); end
    endtask

    task automatic test_skew();
        logic [31:0] exp_d [5];
        logic [3:0]  exp_v [5];
        exp_d[0] = 32'h00000011; exp_v[0] = 4'b0001;
        exp_d[1] = 32'h00002200; exp_v[1] = 4'b0010;
        exp_d[2] = 32'h00330000; exp_v[2] = 4'b0100;
        exp_d[3] = 32'h44000000; exp_v[3] = 4'b1000;
        exp_d[4] = 32'h00000000; exp_v[4] = 4'b0000;
        act_valid = 1'b1; act_vec_in = 32'h44332211;
        for (int m = 0; m < 5; m++) begin
            step();
            act_valid = 1'b0; act_vec_in = 32'h0;
            checks++; if (data_out !== exp_d[m] || data_vld !== exp_v[m] || control !== 1'b0) begin errors++; $display("FAIL skew_t%0d: got %h/%b ctl=%b expected %h/%b ctl=0", m + 1, data_out, data_vld, control, exp_d[m], exp_v[m]); end
        end
    endtask

    task automatic test_bubble();
        logic        in_v [6];
        logic [31:0] in_d [6];
        logic [31:0] exp_d [6];
        logic [3:0]  exp_v [6];
        in_v[0] = 1'b1; in_d[0] = 32'h84838281;
        in_v[1] = 1'b0; in_d[1] = 32'hFFFFFFFF;
        in_v[2] = 1'b1; in_d[2] = 32'h94939291;
        in_v[3] = 1'b0; in_d[3] = 32'h0;
        in_v[4] = 1'b0; in_d[4] = 32'h0;
        in_v[5] = 1'b0; in_d[5] = 32'h0;
        exp_d[0] = 32'h00000081; exp_v[0] = 4'b0001;
        exp_d[1] = 32'h00008200; exp_v[1] = 4'b0010;
        exp_d[2] = 32'h00830091; exp_v[2] = 4'b0101;
        exp_d[3] = 32'h84009200; exp_v[3] = 4'b1010;
        exp_d[4] = 32'h00930000; exp_v[4] = 4'b0100;
        exp_d[5] = 32'h94000000; exp_v[5] = 4'b1000;
        for (int m = 0; m < 6; m++) begin
            act_valid = in_v[m]; act_vec_in = in_d[m];
            step();
            checks++; if (data_out !== exp_d[m] || data_vld !== exp_v[m]) begin errors++; $display("FAIL bubble_t%0d: got %h/%b expected %h/%b", m + 1, data_out, data_vld, exp_d[m], exp_v[m]); end
        end
        act_valid = 1'b0; act_vec_in = 32'h0;
        step();
    endtask

    task automatic test_last_drain();
        logic [31:0] exp_d [5];
        logic [3:0]  exp_v [5];
        logic [3:0]  exp_s [5];
        exp_d[0] = 32'h000000D1; exp_v[0] = 4'b0001;
        exp_d[1] = 32'h0000D200; exp_v[1] = 4'b0010;
        exp_d[2] = 32'h00D30000; exp_v[2] = 4'b0100;
        exp_d[3] = 32'hD4000000; exp_v[3] = 4'b1000;
        exp_d[4] = 32'h00000000; exp_v[4] = 4'b0000;
        // {act_ready, busy, done, wt_ready}
        exp_s[0] = 4'b0100; exp_s[1] = 4'b0100; exp_s[2] = 4'b0100; exp_s[3] = 4'b0011; exp_s[4] = 4'b0001;
        act_valid = 1'b1; act_last = 1'b1; act_vec_in = 32'hD4D3D2D1;
        for (int m = 0; m < 5; m++) begin
            step();
            // Activation offers outside STREAM must be ignored.
            act_valid = (m < 3); act_last = (m < 3); act_vec_in = 32'hEEEEEEEE;
            checks++; if ({act_ready, busy, done, wt_ready} !== exp_s[m]) begin errors++; $display("FAIL last_status_t%0d: got %b expected %b", m + 1, {act_ready, busy, done, wt_ready}, exp_s[m]); end
            checks++; if (data_out !== exp_d[m] || data_vld !== exp_v[m]) begin errors++; $display("FAIL last_data_t%0d: got %h/%b expected %h/%b", m + 1, data_out, data_vld, exp_d[m], exp_v[m]); end
        end
        act_valid = 1'b0; act_last = 1'b0; act_vec_in = 32'h0;
    endtask

    task automatic test_stall_load();
        logic        in_v [7];
        logic [31:0] in_d [7];
        logic [31:0] exp_w [7];
        int          ctl_count = 0;
        in_v[0] = 1'b1; in_d[0] = 32'h04040404; exp_w[0] = 32'h04040404;
        in_v[1] = 1'b1; in_d[1] = 32'h03030303; exp_w[1] = 32'h03030303;
        in_v[2] = 1'b0; in_d[2] = 32'h0;        exp_w[2] = 32'h03030303;
        in_v[3] = 1'b0; in_d[3] = 32'h0;        exp_w[3] = 32'h03030303;
        in_v[4] = 1'b1; in_d[4] = 32'h02020202; exp_w[4] = 32'h02020202;
        in_v[5] = 1'b1; in_d[5] = 32'h01010101; exp_w[5] = 32'h01010101;
        in_v[6] = 1'b1; in_d[6] = 32'hAAAAAAAA; exp_w[6] = 32'h01010101;
        for (int m = 0; m < 7; m++) begin
            wt_valid = in_v[m]; wt_row_in = in_d[m];
            step();
            if (control === 1'b1) ctl_count++;
            checks++; if (control !== in_v[m] && m < 6 || control !== 1'b0 && m == 6 || wt_out !== exp_w[m]) begin errors++; $display("FAIL stall_t%0d: got ctl=%b wt=%h expected wt=%h", m + 1, control, wt_out, exp_w[m]); end
        end
        wt_valid = 1'b0; wt_row_in = 32'h0;
        checks++; if (ctl_count != 4) begin errors++; $display("FAIL stall_ctl_count: got %0d expected 4", ctl_count); end
        checks++; if (act_ready !== 1'b1 || wt_ready !== 1'b0) begin errors++; $display("FAIL stall_state: got act_ready=%b wt_ready=%b expected 1/0", act_ready, wt_ready); end
    endtask

    task automatic test_reset_mid();
        act_valid = 1'b1; act_vec_in = 32'h55667788;
        step();
        act_valid = 1'b0; act_vec_in = 32'h0;
        step();
        checks++; if (data_vld !== 4'b0010) begin errors++; $display("FAIL midrst_inflight: got %b expected 0010", data_vld); end
        #2; reset = 1'b0; #1;
        checks++; if ({control, busy, done, data_vld} !== 7'b0) begin errors++; $display("FAIL midrst_ctrl: got %b expected 0", {control, busy, done, data_vld}); end
        checks++; if (data_out !== 32'h0 || wt_ready !== 1'b1) begin errors++; $display("FAIL midrst_data: got %h wt_ready=%b expected 0/1", data_out, wt_ready); end
        @(negedge clk); reset = 1'b1;
        for (int m = 0; m < 5; m++) begin
            step();
            checks++; if (done !== 1'b0 || busy !== 1'b0 || data_vld !== 4'b0) begin errors++; $display("FAIL midrst_after_t%0d: got done=%b busy=%b vld=%b expected 0", m, done, busy, data_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_load_b2b();
        test_skew();
        test_bubble();
        test_last_drain();
        test_stall_load();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
